mprj_io_serial_loader: RTL and testbench
========================================

Name: mprj_io_serial_loader

Overview:
- Transmit side of the user-project IO configuration chain.
- Fetches per-pad configuration words from the housekeeping/mprj_ctrl register file and shifts them out serially, MSB first, highest pad index first.
- After the last bit it pulses serial_load so every gpio_control_block latches its word.
- Lives in the management SoC next to mprj_ctrl; firmware triggers it and polls busy before driving IO-dependent checkbits.

Parameters:
- NUM_IO, 38, number of pads (words) in the chain.
- CFG_BITS, 13, bits per pad configuration word.
- CLK_DIV, 2, clock cycles per serial_clock half-period; legal values ≥1.
- IDX_W, 6, width of cfg_idx; must satisfy 2**IDX_W ≥ NUM_IO.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy.
- cfg_idx  out  IDX_W  pad index being fetched.
- cfg_data  in  CFG_BITS  config word for cfg_idx; registered source, valid the cycle after cfg_idx changes.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the transfer completes.
- serial_clock  out  1  shift clock to the pad chain.
- serial_data  out  1  shift data; changes only while serial_clock is low.
- serial_load  out  1  latch strobe to the pad chain.

Behaviour:
- Reset values (asynchronous, immediate): busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0, cfg_idx=NUM_IO-1; FSM=IDLE.
- IDLE: start=1 at a rising edge → FETCH; busy rises at that same edge; cfg_idx=NUM_IO-1.
- FETCH (1 cycle): capture cfg_data into the shift register; bit counter=CFG_BITS-1 → SHIFT.
- SHIFT, per bit:
  - serial_data = shreg[MSB], serial_clock low for CLK_DIV cycles, then high for CLK_DIV cycles (2*CLK_DIV cycles per bit).
  - On the falling edge, shift left; the data change coincides with serial_clock falling.
- After bit 0 of a word:
  - if cfg_idx≠0: decrement cfg_idx → FETCH;
  - else → LOAD.
- LOAD: serial_clock=0, serial_data=0, serial_load=1 for CLK_DIV cycles → DONE.
- DONE (1 cycle): done=1, busy=0, serial_load=0, cfg_idx reset to NUM_IO-1 → IDLE.
- Latency: done is high in cycle T = NUM_IO*(1+2*CLK_DIV*CFG_BITS)+CLK_DIV+1 after the start-sampling edge.
- Totals: exactly NUM_IO*CFG_BITS serial_clock rising edges and one serial_load pulse per transfer.
- Boundary conditions:
  - start while busy, including in the DONE cycle: ignored, no queuing.
  - start held high continuously: a new transfer begins at the first IDLE edge after DONE.
  - resetn low mid-transfer: all outputs return to reset values asynchronously; serial_load never asserts for a partial transfer.
  - cfg_data is sampled only in FETCH; changes at any other time have no effect.
  - serial_clock and serial_load are never high in the same cycle.

Decomposition:
- Shared package mprj_ctrl_pkg:
  - FSM state enum (IDLE, FETCH, SHIFT, LOAD, DONE);
  - default constants MPRJ_NUM_IO=38 and MPRJ_CFG_BITS=13.
- One natural sub-module: mprj_serial_clkgen, a CLK_DIV half-period counter emitting phase-rise/phase-fall enables. The shifter and FSM stay in the top block.

Test Plan:
- Reset: NUM_IO=2, CFG_BITS=4, CLK_DIV=1, words {idx1=4'hA, idx0=4'h5}; pulse start → serial_data samples at serial_clock rises read 1,0,1,0,0,1,0,1; 8 rises; serial_load high in cycle 19; done in cycle 20; busy 1 in cycles 1–19.
- Defaults (38×13, CLK_DIV=2): random words via a model of a 38-deep chain of 13-bit registers → after serial_load every model register equals its source word; done at cycle 38*53+3=2017.
- start pulsed in mid-SHIFT and in the DONE cycle → no restart; exactly one serial_load; next start from IDLE runs normally.
- resetn asserted at bit 3 of word 20 → outputs zero within the same cycle; no serial_load; a subsequent start produces a full, correct transfer.
- cfg_data toggled every cycle except in FETCH → shifted data equals the FETCH-sampled values only.
- Protocol checker on all runs: serial_data stable while serial_clock high; serial_load never overlaps serial_clock; serial_clock high time = CLK_DIV cycles exactly.

Source files
------------

// File: rtl/mprj_ctrl_pkg.sv
// Shared definitions for the mprj_ctrl IO configuration logic: chain defaults
// and the serial loader state encoding.
package mprj_ctrl_pkg;

  localparam int MPRJ_NUM_IO   = 38;
  localparam int MPRJ_CFG_BITS = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } mprj_state_e;

endpackage

// File: rtl/mprj_serial_clkgen.sv
// Half-period timer for the pad-chain shift clock: flags the cycle before the
// shift clock should rise and the cycle before it should fall.
module mprj_serial_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             last;

  assign last = (cnt == CNT_W'(CLK_DIV - 1));
  assign rise = en && !phase && last;
  assign fall = en &&  phase && last;

  // Idle holds the timer at the start of a low phase so every bit begins low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mprj_io_serial_loader.sv
// Serialises per-pad configuration words into the user-project IO chain,
// highest pad first and MSB first, then strobes serial_load to latch them.
module mprj_io_serial_loader
  import mprj_ctrl_pkg::*;
#(
  parameter int NUM_IO   = MPRJ_NUM_IO,
  parameter int CFG_BITS = MPRJ_CFG_BITS,
  parameter int CLK_DIV  = 2,
  parameter int IDX_W    = 6
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic [IDX_W-1:0]    cfg_idx,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load
);

  localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int LD_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IO - 1);

  mprj_state_e         state;
  logic [CFG_BITS-1:0] shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [LD_W-1:0]     ld_cnt;
  logic                shift_en;
  logic                sclk_rise;
  logic                sclk_fall;

  assign shift_en = (state == ST_SHIFT);

  mprj_serial_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clock  (clock),
    .resetn (resetn),
    .en     (shift_en),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cfg_idx <= IDX_LAST;
      bit_cnt <= '0;
      ld_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FETCH;
            cfg_idx <= IDX_LAST;
          end
        end
        ST_FETCH: begin
          bit_cnt <= BIT_W'(CFG_BITS - 1);
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Word boundaries are taken on the falling edge of the last bit.
          if (sclk_fall) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - BIT_W'(1);
            end else if (cfg_idx != '0) begin
              cfg_idx <= cfg_idx - IDX_W'(1);
              state   <= ST_FETCH;
            end else begin
              ld_cnt  <= '0;
              state   <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (ld_cnt == LD_W'(CLK_DIV - 1)) begin
            cfg_idx <= IDX_LAST;
            state   <= ST_DONE;
          end else begin
            ld_cnt  <= ld_cnt + LD_W'(1);
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Shift data needs no reset: serial_data is gated by the SHIFT state.
  always_ff @(posedge clock) begin
    if (state == ST_FETCH) begin
      shreg <= cfg_data;
    end else if (shift_en && sclk_fall) begin
      shreg <= shreg << 1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      serial_clock <= 1'b0;
    end else if (sclk_fall || !shift_en) begin
      serial_clock <= 1'b0;
    end else if (sclk_rise) begin
      serial_clock <= 1'b1;
    end
  end

  assign busy        = (state == ST_FETCH) || (state == ST_SHIFT) || (state == ST_LOAD);
  assign done        = (state == ST_DONE);
  assign serial_load = (state == ST_LOAD);
  assign serial_data = shift_en && shreg[CFG_BITS-1];

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Directed bench for mprj_io_serial_loader: a small 2x4 chain (CLK_DIV=1) and
// the default 38x13 chain (CLK_DIV=2) driven from one clock.
module tb_mprj_io_serial_loader;

  logic clock;
  int   tests;
  int   fails;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Small instance: 2 pads x 4 bits, CLK_DIV=1
  logic       resetn_a, start_a, busy_a, done_a, sclk_a, sdata_a, load_a;
  logic [0:0] cfg_idx_a;
  logic [3:0] cfg_data_a;
  assign cfg_data_a = cfg_idx_a[0] ? 4'hA : 4'h5;

  mprj_io_serial_loader #(
    .NUM_IO(2), .CFG_BITS(4), .CLK_DIV(1), .IDX_W(1)
  ) u_dut_a (
    .clock(clock), .resetn(resetn_a), .start(start_a), .cfg_idx(cfg_idx_a),
    .cfg_data(cfg_data_a), .busy(busy_a), .done(done_a), .serial_clock(sclk_a),
    .serial_data(sdata_a), .serial_load(load_a)
  );

  // Default instance: 38 pads x 13 bits, CLK_DIV=2
  logic        resetn_b, start_b, busy_b, done_b, sclk_b, sdata_b, load_b;
  logic [5:0]  cfg_idx_b;
  logic [12:0] cfg_data_b;
  logic [12:0] words [38];

  mprj_io_serial_loader u_dut_b (
    .clock(clock), .resetn(resetn_b), .start(start_b), .cfg_idx(cfg_idx_b),
    .cfg_data(cfg_data_b), .busy(busy_b), .done(done_b), .serial_clock(sclk_b),
    .serial_data(sdata_b), .serial_load(load_b)
  );

  // Protocol watchers, one per instance
  logic pa_sclk, pa_sdata, pb_sclk, pb_sdata;
  int   ha, hb;

  always @(negedge clock) begin
    if (!resetn_a) begin
      pa_sclk = 1'b0; pa_sdata = 1'b0; ha = 0;
    end else begin
      if (sclk_a || load_a) begin
        tests++;
        if (sclk_a && load_a) begin fails++; $display("FAIL proto_a_overlap: sclk=%b load=%b, required not both 1", sclk_a, load_a); end
      end
      if (sclk_a && pa_sclk) begin
        tests++;
        if (sdata_a !== pa_sdata) begin fails++; $display("FAIL proto_a_stable: data=%b, required %b", sdata_a, pa_sdata); end
      end
      if (!sclk_a && pa_sclk) begin
        tests++;
        if (ha != 1) begin fails++; $display("FAIL proto_a_high: high=%0d, required 1", ha); end
      end
      ha = sclk_a ? ha + 1 : 0;
      pa_sclk = sclk_a; pa_sdata = sdata_a;
    end
  end

  always @(negedge clock) begin
    if (!resetn_b) begin
      pb_sclk = 1'b0; pb_sdata = 1'b0; hb = 0;
    end else begin
      if (sclk_b || load_b) begin
        tests++;
        if (sclk_b && load_b) begin fails++; $display("FAIL proto_b_overlap: sclk=%b load=%b, required not both 1", sclk_b, load_b); end
      end
      if (sclk_b && pb_sclk) begin
        tests++;
        if (sdata_b !== pb_sdata) begin fails++; $display("FAIL proto_b_stable: data=%b, required %b", sdata_b, pb_sdata); end
      end
      if (!sclk_b && pb_sclk) begin
        tests++;
        if (hb != 2) begin fails++; $display("FAIL proto_b_high: high=%0d, required 2", hb); end
      end
      hb = sclk_b ? hb + 1 : 0;
      pb_sclk = sclk_b; pb_sdata = sdata_b;
    end
  end

  task automatic new_words();
    for (int w = 0; w < 38; w++) words[w] = 13'($urandom);
  endtask

  // Runs one transfer on the default instance and collects what the chain saw.
  task automatic run_xfer_b(input bit toggle, input int p1, input int p2,
                            output int done_cyc, output int loads, output int rises,
                            output int busy_after, output logic [493:0] chain);
    logic prev_sclk, prev_load, fetch;
    chain = '0; done_cyc = -1; loads = 0; rises = 0; busy_after = 0;
    prev_sclk = 1'b0; prev_load = 1'b0;
    @(negedge clock);
    start_b = 1'b1;
    cfg_data_b = words[cfg_idx_b];
    @(posedge clock);
    for (int c = 1; c <= 2030; c++) begin
      @(negedge clock);
      start_b = (c == p1) || (c == p2);
      fetch = ((c - 1) % 53 == 0) && (c <= 38 * 53);
      if (toggle && !fetch) cfg_data_b = (c % 2 == 1) ? ~words[cfg_idx_b] : 13'($urandom);
      else                  cfg_data_b = words[cfg_idx_b];
      if (sclk_b && !prev_sclk) begin chain = {chain[492:0], sdata_b}; rises++; end
      if (load_b && !prev_load) loads++;
      if (done_b && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc && busy_b) busy_after++;
      prev_sclk = sclk_b; prev_load = load_b;
    end
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    resetn_a = 1'b0; resetn_b = 1'b0; start_a = 1'b0; start_b = 1'b0; cfg_data_b = '0;
    repeat (3) @(negedge clock);
    tests++;
    if ({busy_a, done_a, sclk_a, sdata_a, load_a, cfg_idx_a} !== 6'b00000_1) begin
      fails++; $display("FAIL reset_a: {busy,done,sclk,data,load,idx}=%b, required 000001", {busy_a, done_a, sclk_a, sdata_a, load_a, cfg_idx_a});
    end
    tests++;
    if ({busy_b, done_b, sclk_b, sdata_b, load_b} !== 5'b0 || cfg_idx_b !== 6'd37) begin
      fails++; $display("FAIL reset_b: {busy,done,sclk,data,load}=%b idx=%0d, required 00000 idx 37", {busy_b, done_b, sclk_b, sdata_b, load_b}, cfg_idx_b);
    end
    resetn_a = 1'b1; resetn_b = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_small_pattern();
    logic [7:0] bits;
    int rises;
    logic prev;
    bits = '0; rises = 0; prev = 1'b0;
    start_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      if (sclk_a && !prev) begin bits = {bits[6:0], sdata_a}; rises++; end
      prev = sclk_a;
      tests++;
      if (load_a !== (c == 19)) begin fails++; $display("FAIL small_load c=%0d: %b, required %b", c, load_a, (c == 19)); end
      tests++;
      if (done_a !== (c == 20)) begin fails++; $display("FAIL small_done c=%0d: %b, required %b", c, done_a, (c == 20)); end
      tests++;
      if (busy_a !== (c >= 1 && c <= 19)) begin fails++; $display("FAIL small_busy c=%0d: %b, required %b", c, busy_a, (c <= 19)); end
    end
    tests++;
    if (bits !== 8'b1010_0101) begin fails++; $display("FAIL small_bits: %b, required 10100101", bits); end
    tests++;
    if (rises != 8) begin fails++; $display("FAIL small_rises: %0d, required 8", rises); end
  endtask

  task automatic test_start_held();
    int d1, d2, loads;
    logic prev_load;
    d1 = -1; d2 = -1; loads = 0; prev_load = 1'b0;
    start_a = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      if (c == 22) start_a = 1'b0;
      if (load_a && !prev_load) loads++;
      prev_load = load_a;
      if (done_a) begin if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c; end
      if (c == 21) begin
        tests++;
        if (busy_a !== 1'b0) begin fails++; $display("FAIL held_idle_gap: busy=%b, required 0", busy_a); end
      end
      if (c == 22) begin
        tests++;
        if (busy_a !== 1'b1) begin fails++; $display("FAIL held_restart: busy=%b, required 1", busy_a); end
      end
    end
    tests++;
    if (d1 != 20 || d2 != 41) begin fails++; $display("FAIL held_done: cycles %0d,%0d, required 20,41", d1, d2); end
    tests++;
    if (loads != 2) begin fails++; $display("FAIL held_loads: %0d, required 2", loads); end
  endtask

  task automatic check_chain(input string tag, input logic [493:0] chain);
    for (int w = 0; w < 38; w++) begin
      tests++;
      if (chain[w*13 +: 13] !== words[w]) begin
        fails++; $display("FAIL %s_word%0d: got %h, required %h", tag, w, chain[w*13 +: 13], words[w]);
      end
    end
  endtask

  task automatic test_defaults();
    int dc, ld, rs, ba;
    logic [493:0] ch;
    new_words();
    run_xfer_b(1'b0, -1, -1, dc, ld, rs, ba, ch);
    tests++;
    if (dc != 2017) begin fails++; $display("FAIL dflt_done: cycle %0d, required 2017", dc); end
    tests++;
    if (ld != 1) begin fails++; $display("FAIL dflt_loads: %0d, required 1", ld); end
    tests++;
    if (rs != 494) begin fails++; $display("FAIL dflt_rises: %0d, required 494", rs); end
    tests++;
    if (ba != 0) begin fails++; $display("FAIL dflt_busy_after: %0d, required 0", ba); end
    check_chain("dflt", ch);
  endtask

  task automatic test_start_while_busy();
    int dc, ld, rs, ba;
    logic [493:0] ch;
    new_words();
    run_xfer_b(1'b0, 500, 2017, dc, ld, rs, ba, ch);
    tests++;
    if (dc != 2017) begin fails++; $display("FAIL busy_start_done: cycle %0d, required 2017", dc); end
    tests++;
    if (ld != 1) begin fails++; $display("FAIL busy_start_loads: %0d, required 1", ld); end
    tests++;
    if (ba != 0) begin fails++; $display("FAIL busy_start_restart: busy cycles after done %0d, required 0", ba); end
    check_chain("busy_start", ch);
  endtask

  task automatic test_reset_mid_transfer();
    int dc, ld, rs, ba, loads;
    logic [493:0] ch;
    new_words();
    loads = 0;
    @(negedge clock);
    start_b = 1'b1;
    cfg_data_b = words[cfg_idx_b];
    @(posedge clock);
    // Cycle 1076 is the first high cycle of bit 3 of the 21st word (pad 17).
    for (int c = 1; c <= 1076; c++) begin
      @(negedge clock);
      start_b = 1'b0;
      cfg_data_b = words[cfg_idx_b];
      if (load_b) loads++;
    end
    tests++;
    if (sclk_b !== 1'b1 || sdata_b !== words[17][9]) begin
      fails++; $display("FAIL rst_mid_pre: sclk=%b data=%b, required 1 %b", sclk_b, sdata_b, words[17][9]);
    end
    resetn_b = 1'b0;
    #1;
    tests++;
    if ({busy_b, done_b, sclk_b, sdata_b, load_b} !== 5'b0 || cfg_idx_b !== 6'd37) begin
      fails++; $display("FAIL rst_mid_outputs: {busy,done,sclk,data,load}=%b idx=%0d, required 00000 idx 37", {busy_b, done_b, sclk_b, sdata_b, load_b}, cfg_idx_b);
    end
    repeat (4) begin
      @(negedge clock);
      if (load_b) loads++;
    end
    resetn_b = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (load_b) loads++;
    end
    tests++;
    if (loads != 0) begin fails++; $display("FAIL rst_mid_no_load: load cycles %0d, required 0", loads); end
    new_words();
    run_xfer_b(1'b0, -1, -1, dc, ld, rs, ba, ch);
    tests++;
    if (dc != 2017 || ld != 1) begin fails++; $display("FAIL rst_mid_rerun: done %0d loads %0d, required 2017 1", dc, ld); end
    check_chain("rst_mid_rerun", ch);
  endtask

  task automatic test_cfg_toggle();
    int dc, ld, rs, ba;
    logic [493:0] ch;
    new_words();
    run_xfer_b(1'b1, -1, -1, dc, ld, rs, ba, ch);
    tests++;
    if (dc != 2017 || rs != 494) begin fails++; $display("FAIL toggle_timing: done %0d rises %0d, required 2017 494", dc, rs); end
    check_chain("toggle", ch);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_small_pattern();
    repeat (3) @(negedge clock);
    test_start_held();
    test_defaults();
    repeat (3) @(negedge clock);
    test_start_while_busy();
    repeat (3) @(negedge clock);
    test_reset_mid_transfer();
    repeat (3) @(negedge clock);
    test_cfg_toggle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
